// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the radix-2 divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_radix2_step.sv
// rtl/div_radix2_step.sv - one combinational restoring-division iteration
module div_radix2_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] d;
  logic           unused_rem_msb;

  // The partial remainder never exceeds the divisor, so its top bit stays zero.
  assign unused_rem_msb = rem_i[WIDTH];

  assign sh = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign d  = sh - {1'b0, divisor_i};

  always_comb begin
    rem_o = sh;
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!d[WIDTH]) begin
      rem_o = d;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_radix2_core.sv
// rtl/div_radix2_core.sv - iterative unsigned restoring divider, one quotient bit per cycle
// Optional DIV_RADIX2_EARLY_OUT_EN: finish immediately for zero divisor or dividend < divisor.
module div_radix2_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;

  // Both channels transfer together; tready is held low while reset is asserted.
  assign accept = (state == ST_IDLE) & s_axis_dividend_tvalid & s_axis_divisor_tvalid & ~rst_i;
  assign s_axis_dividend_tready = accept;
  assign s_axis_divisor_tready  = accept;

  div_radix2_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem),
    .quo_i     (quo),
    .divisor_i (divisor),
    .rem_o     (rem_nxt),
    .quo_o     (quo_nxt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      rem                <= '0;
      quo                <= '0;
      divisor            <= '0;
      cnt                <= '0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            divisor <= s_axis_divisor_tdata;
            cnt     <= CNT_W'(WIDTH);
`ifdef DIV_RADIX2_EARLY_OUT_EN
            if (s_axis_divisor_tdata == '0) begin
              quo   <= '1;
              rem   <= {1'b0, s_axis_dividend_tdata};
              state <= ST_DONE;
            end else if (s_axis_dividend_tdata < s_axis_divisor_tdata) begin
              quo   <= '0;
              rem   <= {1'b0, s_axis_dividend_tdata};
              state <= ST_DONE;
            end else begin
              rem   <= '0;
              quo   <= s_axis_dividend_tdata;
              state <= ST_RUN;
            end
`else
            rem   <= '0;
            quo   <= s_axis_dividend_tdata;
            state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          m_axis_dout_tvalid <= 1'b1;
          m_axis_dout_tdata  <= {quo, rem[WIDTH-1:0]};
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
